// File: rtl/demux_pkg.sv
// Shared constants and helpers for the LED demux stepper.
package demux_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Short debounce for simulation; the board default absorbs mechanical bounce.
  localparam int DEB_SIM   = 4;
  localparam int DEB_BOARD = 1000;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/demux_stepper_debouncer.sv
// Synchronizer plus stable-count debouncer for one asynchronous input.
module debouncer
  import demux_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEB_BOARD
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic db
);

  localparam int CW = (clog2(DEBOUNCE_CYCLES + 1) < 1) ? 1 : clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   din_s;

  assign din_s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      cnt  <= '0;
      db   <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
      // Any cycle that agrees with the accepted state restarts the count.
      if (din_s == db) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        db  <= din_s;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux_stepper.sv
// 1-to-N LED demux whose select index is stepped by a debounced button.
module demux_stepper
  import demux_pkg::*;
#(
  parameter  int N_OUT           = 4,
  parameter  int DEBOUNCE_CYCLES = DEB_BOARD,
  parameter  int SYNC_STAGES     = 2,
  localparam int SEL_W           = (clog2(N_OUT) < 1) ? 1 : clog2(N_OUT)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_data,
  input  logic             i_btn,
  input  logic             i_dir,
  output logic [N_OUT-1:0] o_led,
  output logic [SEL_W-1:0] o_sel,
  output logic             o_step
);

  logic [SYNC_STAGES-1:0] data_sync;
  logic                   data_s;
  logic                   btn_db;
  logic                   btn_prev;
  logic                   rise;
  logic [SEL_W-1:0]       sel;
  logic [SEL_W-1:0]       sel_next;
  logic [N_OUT-1:0]       led_next;

  debouncer #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_db (
    .clk (i_clk),
    .rst (i_rst),
    .din (i_btn),
    .db  (btn_db)
  );

  assign data_s = data_sync[SYNC_STAGES-1];
  assign rise   = btn_db & ~btn_prev;

  // i_dir is a quasi-static switch, so it is only looked at on the step cycle.
  always_comb begin
    sel_next = sel;
    if (rise) begin
      if (i_dir == DIR_UP)
        sel_next = (sel == SEL_W'(N_OUT - 1)) ? '0 : sel + 1'b1;
      else
        sel_next = (sel == '0) ? SEL_W'(N_OUT - 1) : sel - 1'b1;
    end
  end

  // Decode from sel_next so a step and a data change land in one clean update.
  for (genvar i = 0; i < N_OUT; i++) begin : g_lane
    assign led_next[i] = data_s && (sel_next == SEL_W'(i));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      data_sync <= '0;
      btn_prev  <= 1'b0;
      sel       <= '0;
      o_led     <= '0;
      o_step    <= 1'b0;
    end else begin
      data_sync <= {data_sync[SYNC_STAGES-2:0], i_data};
      btn_prev  <= btn_db;
      sel       <= sel_next;
      o_led     <= led_next;
      o_step    <= rise;
    end
  end

  assign o_sel = sel;

endmodule

// File: tb/tb_demux_stepper.sv
// Directed bench for demux_stepper with N_OUT=4, DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
module tb_demux_stepper;

  logic       clk = 1'b0;
  logic       rst;
  logic       data;
  logic       btn;
  logic       dir;
  logic [3:0] led;
  logic [1:0] sel;
  logic       step;

  int pass_cnt = 0;
  int total    = 0;
  int steps    = 0;

  demux_stepper #(
    .N_OUT           (4),
    .DEBOUNCE_CYCLES (4),
    .SYNC_STAGES     (2)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_data (data),
    .i_btn  (btn),
    .i_dir  (dir),
    .o_led  (led),
    .o_sel  (sel),
    .o_step (step)
  );

  always #5 clk = ~clk;

  // Advance one edge and sample 1 time unit later; every o_step cycle is tallied.
  task automatic tick();
    @(posedge clk);
    #1;
    if (step) steps++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  // Press held from the current edge: step must appear on the 7th edge, once.
  task automatic press(input logic d, input int exp_sel);
    int s0, first;
    s0 = steps;
    first = 0;
    btn = 1'b1;
    dir = d;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (step && first == 0) first = i;
    end
    check("press_latency", first, 7);
    check("press_pulses", steps - s0, 1);
    check("press_sel", sel, exp_sel);
    check("press_led", led, 32'd1 << exp_sel);
    btn = 1'b0;
    ticks(10);
    check("release_no_step", steps - s0, 1);
  endtask

  initial begin
    int s0, first;
    rst  = 1'b1;
    data = 1'b1;
    btn  = 1'b0;
    dir  = 1'b0;

    // Reset held for 3 edges with data high.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_led", led, 0);
      check("rst_sel", sel, 0);
    end
    rst = 1'b0;
    steps = 0;
    tick(); check("post_rst_led_e1", led, 4'b0000);
    tick(); check("post_rst_led_e2", led, 4'b0000);
    tick(); check("post_rst_led_e3", led, 4'b0001);
    check("post_rst_sel", sel, 0);

    // Routing: data 1->0->1, three-cycle latency, other lanes stay dark.
    data = 1'b0;
    tick(); tick(); check("route_fall_e2", led, 4'b0001);
    tick(); check("route_fall_e3", led, 4'b0000);
    ticks(2);
    data = 1'b1;
    tick(); tick(); check("route_rise_e2", led, 4'b0000);
    tick(); check("route_rise_e3", led, 4'b0001);
    check("route_no_step", steps, 0);

    // Bounce: never four consecutive high cycles.
    for (int r = 0; r < 5; r++) begin
      btn = 1'b1; ticks(3);
      btn = 1'b0; tick();
    end
    ticks(6);
    check("bounce_no_step", steps, 0);
    check("bounce_sel", sel, 0);
    check("bounce_led", led, 4'b0001);

    // Clean press upward.
    press(1'b0, 1);

    // Wrap upward through 3 -> 0, then downward through 0 -> 3.
    press(1'b0, 2);
    press(1'b0, 3);
    press(1'b0, 0);
    press(1'b0, 1);
    press(1'b1, 0);
    press(1'b1, 3);
    check("wrap_down_led", led, 4'b1000);

    // Reset in the middle of a debounce count discards it.
    btn = 1'b1;
    dir = 1'b0;
    ticks(4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_sel", sel, 0);
    check("midrst_led", led, 4'b0000);
    s0 = steps;
    first = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (step && first == 0) first = i;
    end
    check("midrst_latency", first, 7);
    check("midrst_pulses", steps - s0, 1);
    check("midrst_sel_after", sel, 1);
    check("midrst_led_after", led, 4'b0010);
    btn = 1'b0;
    ticks(10);
    check("midrst_release", steps - s0, 1);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
